// File: rtl/lp_term_ctl_if.sv
// Loop-termination controller bus: fetch/DO/count inputs, loop-stack
// handshake, and the jump/status outputs of lp_term_ctl.
//   master : sequencer side (drives fetch, DO, count, loop-stack state)
//   slave  : lp_term_ctl side
interface lp_term_ctl_if #(
  parameter int AW   = 18,
  parameter int CNTW = 14
) ();
  logic            fetch_vld;
  logic [AW-1:0]   PC;
  logic            do_en;
  logic [AW-1:0]   do_end;
  logic [3:0]      do_cond;
  logic [AW-1:0]   do_top;
  logic            sw_pop;
  logic            cnt_push;
  logic [CNTW-1:0] cnt_val;
  logic            cond_true;
  logic [AW+3:0]   TopLP;
  logic            LP_empty;
  logic            LP_full;
  logic [AW+3:0]   LPin;
  logic            PushLP_EN;
  logic            PopLP_EN;
  logic            LPS_CKenb;
  logic [3:0]      cond_sel;
  logic            loop_jmp;
  logic [AW-1:0]   loop_tgt;
  logic [CNTW-1:0] cnt_top;
  logic            CE;
  logic            lp_ovf;
  logic            cnt_ovf;

  modport master (
    output fetch_vld, PC, do_en, do_end, do_cond, do_top, sw_pop,
           cnt_push, cnt_val, cond_true, TopLP, LP_empty, LP_full,
    input  LPin, PushLP_EN, PopLP_EN, LPS_CKenb, cond_sel, loop_jmp,
           loop_tgt, cnt_top, CE, lp_ovf, cnt_ovf
  );

  modport slave (
    input  fetch_vld, PC, do_en, do_end, do_cond, do_top, sw_pop,
           cnt_push, cnt_val, cond_true, TopLP, LP_empty, LP_full,
    output LPin, PushLP_EN, PopLP_EN, LPS_CKenb, cond_sel, loop_jmp,
           loop_tgt, cnt_top, CE, lp_ovf, cnt_ovf
  );
endinterface

// File: rtl/lp_term_ctl.sv
// Loop-termination controller. Pushes DO UNTIL entries onto the external
// loop stack, keeps matching loop-top address and loop-count stacks, and on
// a fetch of the loop end address either jumps back to the loop top or pops.
// Ports:
//   DSPCLK : clock (posedge)
//   T_RST  : asynchronous reset, active-high
//   lp     : lp_term_ctl_if.slave (fetch, DO, count, loop-stack handshake)
module lp_term_ctl #(
  parameter int AW    = 18,
  parameter int CNTW  = 14,
  parameter int DEPTH = 4
) (
  input  logic DSPCLK,
  input  logic T_RST,
  lp_term_ctl_if.slave lp
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0]    COND_CE      = 4'hE;
  localparam logic [3:0]    COND_FOREVER = 4'hF;
  localparam logic [PW-1:0] FULL_PTR     = PW'(DEPTH);

  logic [AW-1:0]   tstk [DEPTH];
  logic [CNTW-1:0] cstk [DEPTH];
  logic [PW-1:0]   tsp, csp, cbase;
  logic [IW-1:0]   t_idx, c_idx;

  logic            pend_vld;
  logic [3:0]      pend_cond;
  logic [AW-1:0]   pend_end, pend_top;

  logic [AW+3:0]   lpin_q;
  logic            push_q, pop_q, ckenb_q, jmp_q, lp_ovf_q, cnt_ovf_q;

  logic [3:0]      code;
  logic [AW-1:0]   tgt;
  logic [CNTW-1:0] ctop;
  logic            ce, match, term, exit_pop, jmp, pop_now, ce_pop, dec;
  logic            push_req, pend_load, pend_clr, ovf_set;
  logic [3:0]      push_cond;
  logic [AW-1:0]   push_end, push_top;

  assign t_idx = IW'(tsp - 1'b1);
  assign c_idx = IW'(csp - 1'b1);
  assign tgt   = (tsp != '0) ? tstk[t_idx] : '0;
  assign ctop  = (csp != '0) ? cstk[c_idx] : '0;
  assign ce    = (ctop == CNTW'(1));
  assign code  = lp.TopLP[AW+3:AW];

  always_comb begin
    // TopLP is stale while a push or pop is in flight, so no match then
    match    = lp.fetch_vld & ~lp.LP_empty & (lp.PC == lp.TopLP[AW-1:0])
               & ~push_q & ~pop_q;
    if (code == COND_CE)           term = ce;
    else if (code == COND_FOREVER) term = 1'b0;
    else                           term = lp.cond_true;
    exit_pop = match & term;
    jmp      = match & ~term;
    pop_now  = exit_pop | (lp.sw_pop & ~lp.LP_empty);
    ce_pop   = exit_pop & (code == COND_CE);
    dec      = jmp & (code == COND_CE);
    // count-stack pop is applied before a coincident cnt_push
    cbase    = (ce_pop && csp != '0) ? csp - 1'b1 : csp;

    // A pop takes the cycle; a DO arriving then is parked and issued next cycle
    push_req  = 1'b0;
    pend_load = 1'b0;
    pend_clr  = 1'b0;
    ovf_set   = 1'b0;
    push_cond = lp.do_cond;
    push_end  = lp.do_end;
    push_top  = lp.do_top;
    if (pop_now) begin
      if (lp.do_en) begin
        if (pend_vld) ovf_set   = 1'b1;
        else          pend_load = 1'b1;
      end
    end else if (pend_vld) begin
      pend_clr  = 1'b1;
      push_cond = pend_cond;
      push_end  = pend_end;
      push_top  = pend_top;
      if (lp.LP_full) ovf_set  = 1'b1;
      else            push_req = 1'b1;
      if (lp.do_en)   ovf_set  = 1'b1;
    end else if (lp.do_en) begin
      if (lp.LP_full) ovf_set  = 1'b1;
      else            push_req = 1'b1;
    end
  end

  always_ff @(posedge DSPCLK or posedge T_RST) begin
    if (T_RST) begin
      tsp       <= '0;
      csp       <= '0;
      pend_vld  <= 1'b0;
      pend_cond <= '0;
      pend_end  <= '0;
      pend_top  <= '0;
      lpin_q    <= '0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      ckenb_q   <= 1'b1;
      jmp_q     <= 1'b0;
      lp_ovf_q  <= 1'b0;
      cnt_ovf_q <= 1'b0;
    end else begin
      push_q   <= push_req;
      pop_q    <= pop_now;
      ckenb_q  <= ~(push_req | pop_now);
      jmp_q    <= jmp;
      lp_ovf_q <= lp_ovf_q | ovf_set;
      if (push_req) lpin_q <= {push_cond, push_end};

      if (pend_load) begin
        pend_vld  <= 1'b1;
        pend_cond <= lp.do_cond;
        pend_end  <= lp.do_end;
        pend_top  <= lp.do_top;
      end else if (pend_clr) begin
        pend_vld  <= 1'b0;
      end

      if (push_req && tsp != FULL_PTR) tsp <= tsp + 1'b1;
      else if (pop_now && tsp != '0)   tsp <= tsp - 1'b1;

      if (lp.cnt_push) begin
        if (cbase != FULL_PTR) csp <= cbase + 1'b1;
        else begin
          csp       <= cbase;
          cnt_ovf_q <= 1'b1;
        end
      end else if (ce_pop) begin
        csp <= cbase;
      end
    end
  end

  // Stack storage is qualified by the pointers and needs no reset
  always_ff @(posedge DSPCLK) begin
    if (push_req && tsp != FULL_PTR) tstk[IW'(tsp)] <= push_top;
    if (lp.cnt_push) begin
      if (cbase != FULL_PTR) cstk[IW'(cbase)] <= lp.cnt_val;
    end else if (dec && csp != '0) begin
      cstk[c_idx] <= ctop - 1'b1;
    end
  end

  assign lp.LPin      = lpin_q;
  assign lp.PushLP_EN = push_q;
  assign lp.PopLP_EN  = pop_q;
  assign lp.LPS_CKenb = ckenb_q;
  assign lp.cond_sel  = code;
  assign lp.loop_jmp  = jmp_q;
  assign lp.loop_tgt  = tgt;
  assign lp.cnt_top   = ctop;
  assign lp.CE        = ce;
  assign lp.lp_ovf    = lp_ovf_q;
  assign lp.cnt_ovf   = cnt_ovf_q;
endmodule

// File: tb/tb_lp_term_ctl.sv
module tb_lp_term_ctl;
  logic clk = 1'b0;
  logic rst;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  lp_term_ctl_if bus ();

  lp_term_ctl #(.AW(18), .CNTW(14), .DEPTH(4)) dut (
    .DSPCLK(clk),
    .T_RST (rst),
    .lp    (bus)
  );

  // External 4-deep loop stack reacting to PushLP_EN / PopLP_EN
  logic [21:0] mstk [4];
  logic [2:0]  mcnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mcnt <= '0;
    else if (bus.PushLP_EN && mcnt < 3'd4) begin
      mstk[mcnt[1:0]] <= bus.LPin;
      mcnt <= mcnt + 3'd1;
    end else if (bus.PopLP_EN && mcnt != 3'd0) begin
      mcnt <= mcnt - 3'd1;
    end
  end
  assign bus.TopLP    = (mcnt != 3'd0) ? mstk[mcnt[1:0] - 2'd1] : '0;
  assign bus.LP_empty = (mcnt == 3'd0);
  assign bus.LP_full  = (mcnt == 3'd4);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [3:0] c, input logic [17:0] e, input logic [17:0] t);
    bus.do_en = 1'b1; bus.do_cond = c; bus.do_end = e; bus.do_top = t;
    tick();
    bus.do_en = 1'b0;
  endtask

  task automatic fetch(input logic [17:0] pc);
    bus.fetch_vld = 1'b1; bus.PC = pc;
    tick();
    bus.fetch_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.fetch_vld = 0; bus.PC = '0; bus.do_en = 0; bus.do_end = '0;
    bus.do_cond = '0; bus.do_top = '0; bus.sw_pop = 0; bus.cnt_push = 0;
    bus.cnt_val = '0; bus.cond_true = 0;
    tick(); tick();
    chk("rst_push",  bus.PushLP_EN, 0);
    chk("rst_pop",   bus.PopLP_EN, 0);
    chk("rst_ckenb", bus.LPS_CKenb, 1);
    chk("rst_jmp",   bus.loop_jmp, 0);
    chk("rst_lpin",  bus.LPin, 0);
    chk("rst_tgt",   bus.loop_tgt, 0);
    chk("rst_cnt",   bus.cnt_top, 0);
    chk("rst_ovf",   {bus.lp_ovf, bus.cnt_ovf}, 0);
    rst = 1'b0;
    tick();

    // 1. CE loop, count 3
    bus.cnt_push = 1; bus.cnt_val = 14'd3; tick(); bus.cnt_push = 0;
    chk("t1_cnt3", bus.cnt_top, 3);
    do_issue(4'hE, 18'h100, 18'h0F0);
    chk("t1_push",  bus.PushLP_EN, 1);
    chk("t1_lpin",  bus.LPin, {4'hE, 18'h100});
    chk("t1_ckenb", bus.LPS_CKenb, 0);
    chk("t1_tgt",   bus.loop_tgt, 18'h0F0);
    tick();
    chk("t1_push_off", bus.PushLP_EN, 0);
    chk("t1_ckenb_on", bus.LPS_CKenb, 1);
    chk("t1_csel",  bus.cond_sel, 4'hE);
    fetch(18'h100);
    chk("t1_jmp1",  bus.loop_jmp, 1);
    chk("t1_tgt1",  bus.loop_tgt, 18'h0F0);
    chk("t1_cnt2",  bus.cnt_top, 2);
    fetch(18'h100);
    chk("t1_jmp2",  bus.loop_jmp, 1);
    chk("t1_cnt1",  bus.cnt_top, 1);
    chk("t1_ce",    bus.CE, 1);
    fetch(18'h100);
    chk("t1_pop",   bus.PopLP_EN, 1);
    chk("t1_nojmp", bus.loop_jmp, 0);
    chk("t1_cntpop", bus.cnt_top, 0);
    chk("t1_ckenb_pop", bus.LPS_CKenb, 0);
    tick();
    chk("t1_empty", bus.LP_empty, 1);
    chk("t1_pop_off", bus.PopLP_EN, 0);

    // 2. FOREVER loop, then software pop
    do_issue(4'hF, 18'h200, 18'h1F0); tick();
    for (int i = 0; i < 5; i++) begin
      fetch(18'h200);
      chk("t2_jmp", bus.loop_jmp, 1);
      chk("t2_nopop", bus.PopLP_EN, 0);
      chk("t2_tgt", bus.loop_tgt, 18'h1F0);
    end
    bus.sw_pop = 1; tick(); bus.sw_pop = 0;
    chk("t2_swpop", bus.PopLP_EN, 1);
    tick();
    chk("t2_swpop_once", bus.PopLP_EN, 0);
    chk("t2_empty", bus.LP_empty, 1);
    chk("t2_tgt0", bus.loop_tgt, 0);

    // 5. Flag loop on condition 3
    do_issue(4'h3, 18'h500, 18'h4F0); tick();
    chk("t5_csel0", bus.cond_sel, 4'h3);
    bus.cond_true = 0; fetch(18'h500);
    chk("t5_jmp", bus.loop_jmp, 1);
    chk("t5_csel1", bus.cond_sel, 4'h3);
    bus.cond_true = 1; fetch(18'h500); bus.cond_true = 0;
    chk("t5_pop", bus.PopLP_EN, 1);
    chk("t5_nojmp", bus.loop_jmp, 0);
    chk("t5_csel2", bus.cond_sel, 4'h3);
    tick();

    // 4. DO coincident with a terminating CE match
    bus.cnt_push = 1; bus.cnt_val = 14'd1; tick(); bus.cnt_push = 0;
    do_issue(4'hE, 18'h300, 18'h2F0); tick();
    bus.fetch_vld = 1; bus.PC = 18'h300;
    do_issue(4'hF, 18'h400, 18'h3F0);
    bus.fetch_vld = 0;
    chk("t4_pop_n1", bus.PopLP_EN, 1);
    chk("t4_nopush_n1", bus.PushLP_EN, 0);
    tick();
    chk("t4_push_n2", bus.PushLP_EN, 1);
    chk("t4_nopop_n2", bus.PopLP_EN, 0);
    chk("t4_lpin", bus.LPin, {4'hF, 18'h400});
    chk("t4_tgt", bus.loop_tgt, 18'h3F0);
    chk("t4_cnt", bus.cnt_top, 0);
    tick();
    chk("t4_top", bus.TopLP, {4'hF, 18'h400});
    chk("t4_ckenb", bus.LPS_CKenb, 1);
    bus.sw_pop = 1; tick(); bus.sw_pop = 0; tick();

    // Count-stack overflow
    for (int i = 0; i < 4; i++) begin
      bus.cnt_push = 1; bus.cnt_val = 14'(10 + i); tick();
    end
    bus.cnt_val = 14'd14; tick(); bus.cnt_push = 0;
    chk("cnt_ovf", bus.cnt_ovf, 1);
    chk("cnt_keep", bus.cnt_top, 13);

    // 3. Nest 4 DOs, 5th overflows
    for (int i = 0; i < 4; i++) begin
      do_issue(4'hF, 18'(18'h700 + i), 18'(18'h680 + i));
      chk("t3_push", bus.PushLP_EN, 1);
      tick();
    end
    chk("t3_full", bus.LP_full, 1);
    do_issue(4'hF, 18'h7FF, 18'h6FF);
    chk("t3_nopush", bus.PushLP_EN, 0);
    chk("t3_ovf", bus.lp_ovf, 1);
    chk("t3_tgt", bus.loop_tgt, 18'h683);
    tick(); tick();
    chk("t3_ovf_sticky", bus.lp_ovf, 1);

    // 6. Asynchronous reset mid-loop
    #3 rst = 1'b1;
    #1;
    chk("t6_ovf", {bus.lp_ovf, bus.cnt_ovf}, 0);
    chk("t6_tgt", bus.loop_tgt, 0);
    chk("t6_cnt", bus.cnt_top, 0);
    chk("t6_ckenb", bus.LPS_CKenb, 1);
    chk("t6_push", {bus.PushLP_EN, bus.PopLP_EN, bus.loop_jmp}, 0);
    tick(); rst = 1'b0; tick();
    do_issue(4'hE, 18'h800, 18'h7F0);
    chk("t6_repush", bus.PushLP_EN, 1);
    chk("t6_lpin", bus.LPin, {4'hE, 18'h800});
    chk("t6_retgt", bus.loop_tgt, 18'h7F0);
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
